// File: rtl/ssr_calc_pkg.sv
// rtl/ssr_calc_pkg.sv - shared widths and slice helpers for ssr_calc
package ssr_calc_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ANTENA_NUM_DEF = 1;

  function automatic int lane_off(input int i, input int w);
    return i * w;
  endfunction

  function automatic int sq_off(input int i, input int w);
    return i * 2 * w;
  endfunction

  // A single lane needs no carry headroom, so the total collapses to 2W.
  function automatic int total_width(input int w, input int n);
    return (n > 1) ? (2 * w + $clog2(n)) : (2 * w);
  endfunction

endpackage

// File: rtl/ssr_calc_lane.sv
// rtl/ssr_calc_lane.sv - one antenna lane: register re^2/im^2, then register their sum
module ssr_calc_lane #(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [W-1:0]  re_i,
  input  logic signed [W-1:0]  im_i,
  output logic [2*W-1:0]       ssr_o
);

  logic signed [2*W-1:0] re_x;
  logic signed [2*W-1:0] im_x;
  logic signed [2*W-1:0] sq_re_d;
  logic signed [2*W-1:0] sq_im_d;
  logic [2*W-1:0]        sq_re_q;
  logic [2*W-1:0]        sq_im_q;
  logic [2*W-1:0]        ssr_d;
  logic [2*W-1:0]        ssr_q;

  // Extend before multiplying so the full 2W product is kept; a square is never negative.
  assign re_x    = $signed({{W{re_i[W-1]}}, re_i});
  assign im_x    = $signed({{W{im_i[W-1]}}, im_i});
  assign sq_re_d = re_x * re_x;
  assign sq_im_d = im_x * im_x;
  assign ssr_d   = sq_re_q + sq_im_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_re_q <= '0;
      sq_im_q <= '0;
      ssr_q   <= '0;
    end else begin
      sq_re_q <= $unsigned(sq_re_d);
      sq_im_q <= $unsigned(sq_im_d);
      ssr_q   <= ssr_d;
    end
  end

  assign ssr_o = ssr_q;

endmodule

// File: rtl/ssr_calc.sv
// rtl/ssr_calc.sv - pipelined per-antenna |x|^2 with valid tracking
// Optional lane total enabled by SSR_CALC_TOTAL_EN.
module ssr_calc
  import ssr_calc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ANTENA_NUM = ANTENA_NUM_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  input  logic [ANTENA_NUM*DATA_WIDTH-1:0]       real_part,
  input  logic [ANTENA_NUM*DATA_WIDTH-1:0]       imag_part,
  output logic                                   out_valid,
  output logic [2*ANTENA_NUM*DATA_WIDTH-1:0]     ssr
`ifdef SSR_CALC_TOTAL_EN
  ,
  output logic [total_width(DATA_WIDTH, ANTENA_NUM)-1:0] ssr_total,
  output logic                                   total_valid
`endif
);

  localparam int W = DATA_WIDTH;
  localparam int N = ANTENA_NUM;

  logic [1:0] valid_q;
  logic [1:0] valid_d;

  assign valid_d = {valid_q[0], in_valid};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q[1];

  for (genvar i = 0; i < N; i++) begin : g_lane
    ssr_calc_lane #(.W(W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .re_i  (real_part[lane_off(i, W) +: W]),
      .im_i  (imag_part[lane_off(i, W) +: W]),
      .ssr_o (ssr[sq_off(i, W) +: 2*W])
    );
  end

`ifdef SSR_CALC_TOTAL_EN
  localparam int TW = total_width(W, N);

  logic [TW-1:0] total_d;
  logic [TW-1:0] total_q;
  logic          total_valid_q;

  always_comb begin
    total_d = '0;
    for (int i = 0; i < N; i++) begin
      total_d = total_d + TW'(ssr[sq_off(i, W) +: 2*W]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q       <= '0;
      total_valid_q <= 1'b0;
    end else begin
      total_q       <= total_d;
      total_valid_q <= valid_q[1];
    end
  end

  assign ssr_total   = total_q;
  assign total_valid = total_valid_q;
`endif

endmodule

// File: tb/tb_ssr_calc.sv
// tb/tb_ssr_calc.sv - self-checking bench for ssr_calc (W=32/N=1 and W=16/N=4 instances)
module tb_ssr_calc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         va;
  logic [31:0]  re_a, im_a;
  logic         ova;
  logic [63:0]  ssr_a;
  logic         vb;
  logic [63:0]  re_b, im_b;
  logic         ovb;
  logic [127:0] ssr_b;
`ifdef SSR_CALC_TOTAL_EN
  logic [63:0]  tot_a;
  logic         tva;
  logic [33:0]  tot_b;
  logic         tvb;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ssr_calc #(.DATA_WIDTH(32), .ANTENA_NUM(1)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (va),
    .real_part (re_a),
    .imag_part (im_a),
    .out_valid (ova),
    .ssr       (ssr_a)
`ifdef SSR_CALC_TOTAL_EN
    ,
    .ssr_total   (tot_a),
    .total_valid (tva)
`endif
  );

  ssr_calc #(.DATA_WIDTH(16), .ANTENA_NUM(4)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vb),
    .real_part (re_b),
    .imag_part (im_b),
    .out_valid (ovb),
    .ssr       (ssr_b)
`ifdef SSR_CALC_TOTAL_EN
    ,
    .ssr_total   (tot_b),
    .total_valid (tvb)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pow32(input logic [31:0] re, input logic [31:0] im);
    longint r, m;
    r = longint'($signed(re));
    m = longint'($signed(im));
    return 64'(r * r) + 64'(m * m);
  endfunction

  function automatic logic [31:0] pow16(input logic [15:0] re, input logic [15:0] im);
    longint r, m;
    r = longint'($signed(re));
    m = longint'($signed(im));
    return 32'(r * r + m * m);
  endfunction

  function automatic logic [127:0] vec16(input logic [63:0] re, input logic [63:0] im);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = pow16(re[i*16 +: 16], im[i*16 +: 16]);
    return v;
  endfunction

  function automatic logic [33:0] sum16(input logic [63:0] re, input logic [63:0] im);
    longint s;
    s = 0;
    for (int i = 0; i < 4; i++) s += longint'(pow16(re[i*16 +: 16], im[i*16 +: 16]));
    return 34'(s);
  endfunction

  task automatic single_a(input logic [31:0] re, input logic [31:0] im,
                          input logic [63:0] exp, input string tag);
    re_a = re; im_a = im; va = 1'b1;
    @(negedge clk);
    chk({tag, " valid_c1"}, ova, 1'b0);
    va = 1'b0; re_a = $urandom; im_a = $urandom;
    @(negedge clk);
    chk({tag, " valid_c2"}, ova, 1'b1);
    chk({tag, " ssr"}, ssr_a, exp);
    @(negedge clk);
    chk({tag, " valid_c3"}, ova, 1'b0);
  endtask

  logic [63:0]  qa[$];
  logic [127:0] qb[$];
  logic [33:0]  qt[$];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, ia;
    logic [63:0] e64;

    rst = 1'b1; va = 1'b0; vb = 1'b0;
    re_a = '0; im_a = '0; re_b = '0; im_b = '0;
    #12;
    chk("reset ova", ova, 1'b0);
    chk("reset ssr_a", ssr_a, 64'd0);
    chk("reset ovb", ovb, 1'b0);
    chk("reset ssr_b", ssr_b, 128'd0);
`ifdef SSR_CALC_TOTAL_EN
    chk("reset tva", tva, 1'b0);
    chk("reset tot_b", tot_b, 34'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    single_a(32'd3, 32'd4, 64'd25, "t_3_4");
    single_a(32'h8000_0000, 32'h8000_0000, 64'h8000_0000_0000_0000, "t_min_min");
    single_a(32'hffff_ffff, 32'd0, 64'd1, "t_m1_0");
    single_a(32'd0, 32'd0, 64'd0, "t_0_0");

    // Four-lane directed vector; lane 0 occupies the low slice.
    re_b = {16'h0000, 16'h7fff, 16'hfffd, 16'h0001};
    im_b = {16'hfffb, 16'h8000, 16'h0002, 16'h0001};
    vb = 1'b1;
    @(negedge clk);
    vb = 1'b0;
    @(negedge clk);
    chk("n4 valid", ovb, 1'b1);
    chk("n4 lane0", ssr_b[31:0], 32'd2);
    chk("n4 lane1", ssr_b[63:32], 32'd13);
    chk("n4 lane2", ssr_b[95:64], 32'd2147418113);
    chk("n4 lane3", ssr_b[127:96], 32'd25);
`ifdef SSR_CALC_TOTAL_EN
    chk("n4 total_valid_c2", tvb, 1'b0);
`endif
    @(negedge clk);
    chk("n4 valid_c3", ovb, 1'b0);
`ifdef SSR_CALC_TOTAL_EN
    chk("n4 total_valid_c3", tvb, 1'b1);
    chk("n4 total", tot_b, 34'd2147418153);
    @(negedge clk);
    chk("n4 total_valid_c4", tvb, 1'b0);
`endif

    // Asynchronous reset with two samples in flight.
    re_a = $urandom; im_a = $urandom; va = 1'b1;
    @(negedge clk);
    re_a = $urandom; im_a = $urandom; va = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst ova", ova, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst ova", ova, 1'b0);
    chk("async_rst ssr_a", ssr_a, 64'd0);
    chk("async_rst ssr_b", ssr_b, 128'd0);
    @(negedge clk);
    va = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst quiet %0d", k), ova, 1'b0);
    end
    ra = $urandom; ia = $urandom;
    single_a(ra, ia, pow32(ra, ia), "post_rst new");

    // 100-vector back-to-back stream on both instances.
    for (int c = 0; c < 105; c++) begin
      @(negedge clk);
      chk($sformatf("stream ova c%0d", c), ova, (c >= 2 && c <= 101));
      chk($sformatf("stream ovb c%0d", c), ovb, (c >= 2 && c <= 101));
      if (ova) begin
        if (qa.size() == 0) chk("stream a underflow", 1'b1, 1'b0);
        else begin e64 = qa.pop_front(); chk($sformatf("stream ssr_a c%0d", c), ssr_a, e64); end
      end
      if (ovb) begin
        if (qb.size() == 0) chk("stream b underflow", 1'b1, 1'b0);
        else chk($sformatf("stream ssr_b c%0d", c), ssr_b, qb.pop_front());
      end
`ifdef SSR_CALC_TOTAL_EN
      chk($sformatf("stream tvb c%0d", c), tvb, (c >= 3 && c <= 102));
      if (tvb) begin
        if (qt.size() == 0) chk("stream t underflow", 1'b1, 1'b0);
        else chk($sformatf("stream tot_b c%0d", c), tot_b, qt.pop_front());
      end
`endif
      if (c < 100) begin
        re_a = $urandom; im_a = $urandom;
        if (c % 17 == 5) begin re_a = 32'h8000_0000; im_a = 32'h8000_0000; end
        re_b = {$urandom, $urandom}; im_b = {$urandom, $urandom};
        va = 1'b1; vb = 1'b1;
        qa.push_back(pow32(re_a, im_a));
        qb.push_back(vec16(re_b, im_b));
        qt.push_back(sum16(re_b, im_b));
      end else begin
        va = 1'b0; vb = 1'b0;
      end
    end
    chk("stream a drained", 32'(qa.size()), 32'd0);
    chk("stream b drained", 32'(qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
